// File: rtl/spi_master_multi.sv
// SPI master: programmable width, bit order, CPOL/CPHA, SCLK divider and one-hot active-low chip selects.
// Config is captured when start is accepted, so the front end may change inputs mid-transfer.
module spi_master_multi #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clock_polarity,
    input  logic                  clock_phase,
    input  logic                  lsb_first,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [CS_W-1:0]       cs_select,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk_o,
    output logic [NUM_CS-1:0]     cs_o,
    output logic                  sdo,
    input  logic                  sdi
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    localparam int EW = $clog2(2 * DATA_WIDTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [NUM_CS-1:0]     cs_q, cs_d, cs_sel_n;
    logic                  sclk_q, sclk_d, sdo_q, sdo_d, busy_q, busy_d, done_q, done_d;

    logic [DATA_WIDTH-1:0] tx_src, tx_shift;
    logic                  lsb_src, out_bit, half_done, sample_edge;

    // An out-of-range select shifts the single zero out of the vector, leaving every CS released.
    assign cs_sel_n = ~(NUM_CS'(1) << cs_select);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // In IDLE the first bit comes straight from the inputs so CPHA=0 can present it during LEAD.
        tx_src      = (state_q == ST_IDLE) ? tx_data : tx_q;
        lsb_src     = (state_q == ST_IDLE) ? lsb_first : lsb_q;
        out_bit     = lsb_src ? tx_src[0] : tx_src[DATA_WIDTH-1];
        tx_shift    = lsb_src ? (tx_src >> 1) : (tx_src << 1);
        half_done   = (cnt_q == div_q);
        sample_edge = cpha_q ? edge_q[0] : ~edge_q[0];

        case (state_q)
            ST_IDLE: begin
                sclk_d = clock_polarity;
                sdo_d  = 1'b0;
                cs_d   = '1;
                busy_d = 1'b0;
                if (start && !done_q) begin
                    state_d = ST_LEAD;
                    cpol_d  = clock_polarity;
                    cpha_d  = clock_phase;
                    lsb_d   = lsb_first;
                    div_d   = clk_div;
                    cnt_d   = '0;
                    edge_d  = '0;
                    rx_sh_d = '0;
                    cs_d    = cs_sel_n;
                    busy_d  = 1'b1;
                    if (!clock_phase) begin
                        sdo_d = out_bit;
                        tx_d  = tx_shift;
                    end else begin
                        tx_d = tx_data;
                    end
                end
            end
            ST_LEAD: begin
                if (half_done) begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (half_done) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (sample_edge) begin
                        rx_sh_d = lsb_q ? {sdi, rx_sh_q[DATA_WIDTH-1:1]}
                                        : {rx_sh_q[DATA_WIDTH-2:0], sdi};
                    end else if (edge_q != LAST_EDGE) begin
                        sdo_d = out_bit;
                        tx_d  = tx_shift;
                    end
                    if (edge_q == LAST_EDGE) begin
                        state_d = ST_TRAIL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (half_done) begin
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    busy_d    = 1'b0;
                    cs_d      = '1;
                    sdo_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            cs_q      <= '1;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk_o  = sclk_q;
    assign cs_o    = cs_q;
    assign sdo     = sdo_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: an 8-bit and a 16-bit instance, one selected at a time, checked
// against a pin-level SPI slave model and timing derived from the half-period H.
module tb_spi_master_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, cpol, cpha, lsb, start, sel16, loop, slave_sdi;
    logic [7:0]  clk_div;
    logic [2:0]  cs_select;
    logic [15:0] tx;

    logic        busy8, done8, sclk8, sdo8, busy16, done16, sclk16, sdo16;
    logic [7:0]  rx8;
    logic [15:0] rx16;
    logic [3:0]  cs8, cs16;
    logic        start8, start16, sdi8, sdi16;

    logic        busy_m, done_m, sclk_m, sdo_m;
    logic [15:0] rx_m;
    logic [3:0]  cs_m;

    assign start8  = start & ~sel16;
    assign start16 = start & sel16;
    assign sdi8    = loop ? sdo8 : slave_sdi;
    assign sdi16   = loop ? sdo16 : slave_sdi;
    assign busy_m  = sel16 ? busy16 : busy8;
    assign done_m  = sel16 ? done16 : done8;
    assign sclk_m  = sel16 ? sclk16 : sclk8;
    assign sdo_m   = sel16 ? sdo16 : sdo8;
    assign rx_m    = sel16 ? rx16 : {8'h00, rx8};
    assign cs_m    = sel16 ? cs16 : cs8;

    spi_master_multi #(.DATA_WIDTH(8), .NUM_CS(4), .DIV_WIDTH(8), .CS_W(3)) u_dut8 (
        .clk(clk), .rst(rst), .enable(enable), .clock_polarity(cpol), .clock_phase(cpha),
        .lsb_first(lsb), .clk_div(clk_div), .cs_select(cs_select), .start(start8),
        .tx_data(tx[7:0]), .busy(busy8), .done(done8), .rx_data(rx8), .sclk_o(sclk8),
        .cs_o(cs8), .sdo(sdo8), .sdi(sdi8)
    );

    spi_master_multi #(.DATA_WIDTH(16), .NUM_CS(4), .DIV_WIDTH(8), .CS_W(3)) u_dut16 (
        .clk(clk), .rst(rst), .enable(enable), .clock_polarity(cpol), .clock_phase(cpha),
        .lsb_first(lsb), .clk_div(clk_div), .cs_select(cs_select), .start(start16),
        .tx_data(tx), .busy(busy16), .done(done16), .rx_data(rx16), .sclk_o(sclk16),
        .cs_o(cs16), .sdo(sdo16), .sdi(sdi16)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer; stall_at/mid_start_at/rst_at < 0 disable those disturbances.
    task automatic run_xfer(input bit w16, input bit p_cpol, input bit p_cpha, input bit p_lsb,
                            input int div, input int sel, input logic [15:0] txw,
                            input bit p_loop, input logic [15:0] sw, input int stall_at,
                            input int stall_len, input int mid_start_at, input int rst_at);
        int w, h, k, act, edges, rises, last_act, ncap, exp_done, done_k, extra;
        int bad_int, bad_stable, bad_cs, bad_frz;
        bit finished, got_done, smp;
        logic prev_sclk, prev_sdo;
        logic [15:0] mask, exp_rx, cap;
        logic [3:0] exp_cs;

        w        = w16 ? 16 : 8;
        h        = div + 1;
        mask     = w16 ? 16'hFFFF : 16'h00FF;
        exp_rx   = (p_loop ? txw : sw) & mask;
        exp_cs   = 4'hF;
        if (sel < 4) exp_cs[sel] = 1'b0;
        exp_done = (2 * w + 2) * h + stall_len;

        sel16 = w16; cpol = p_cpol; cpha = p_cpha; lsb = p_lsb;
        clk_div = 8'(div); cs_select = 3'(sel); tx = txw; loop = p_loop;
        slave_sdi = 1'b0; enable = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_sclk", sclk_m, p_cpol);
        check("idle_cs", cs_m, 4'hF);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        k = 0; act = 0; edges = 0; rises = 0; last_act = 0; ncap = 0; done_k = 0;
        bad_int = 0; bad_stable = 0; bad_cs = 0; bad_frz = 0;
        finished = 1'b0; got_done = 1'b0;
        prev_sclk = p_cpol; prev_sdo = sdo_m; cap = '0;

        while (!finished) begin
            if (rst_at >= 0 && k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_cs", cs_m, 4'hF);
                check("rst_busy", busy_m, 1'b0);
                check("rst_done", done_m, 1'b0);
                check("rst_rx", rx_m, 16'h0);
                check("rst_sdo", sdo_m, 1'b0);
                rst = 1'b0;
                return;
            end
            if (sclk_m !== prev_sclk) begin
                edges++;
                if (sclk_m === 1'b1) rises++;
                if (edges > 1 && act - last_act != h) bad_int++;
                last_act = act;
                smp = p_cpha ? (edges % 2 == 0) : (edges % 2 == 1);
                if (smp) begin
                    if (sdo_m !== prev_sdo) bad_stable++;
                    if (ncap < w) begin
                        if (p_lsb) cap[ncap] = prev_sdo;
                        else       cap[w-1-ncap] = prev_sdo;
                    end
                    ncap++;
                end else if (p_cpha && edges < 2 * w) begin
                    slave_sdi = p_lsb ? sw[(edges-1)/2] : sw[w-1-(edges-1)/2];
                end else if (!p_cpha && edges < 2 * w) begin
                    slave_sdi = p_lsb ? sw[edges/2] : sw[w-1-edges/2];
                end
            end
            if (k == 0 && !p_cpha) slave_sdi = p_lsb ? sw[0] : sw[w-1];
            if (k == 1) check("busy_after_start", busy_m, 1'b1);
            if (done_m === 1'b1) begin
                got_done = 1'b1;
                done_k   = k;
                finished = 1'b1;
            end else begin
                if (cs_m !== exp_cs) bad_cs++;
                prev_sclk = sclk_m;
                prev_sdo  = sdo_m;
                start = (k == mid_start_at);
                if (stall_len > 0 && k == stall_at) begin
                    enable = 1'b0;
                    repeat (stall_len) begin
                        @(negedge clk);
                        k++;
                        if (sclk_m !== prev_sclk || sdo_m !== prev_sdo || cs_m !== exp_cs ||
                            done_m !== 1'b0) bad_frz++;
                    end
                    enable = 1'b1;
                end
                @(negedge clk);
                k++;
                act++;
                if (k > 4000) begin
                    check("done_timeout", 32'(k), 32'(exp_done));
                    finished = 1'b1;
                end
            end
        end
        start = 1'b0;

        if (got_done) begin
            check("done_cycle", done_k, exp_done);
            check("rx_data", rx_m, exp_rx);
            check("busy_at_done", busy_m, 1'b0);
            check("cs_at_done", cs_m, 4'hF);
            check("sdo_idle", sdo_m, 1'b0);
            check("sclk_edges", edges, 2 * w);
            check("sclk_rises", rises, w);
            check("half_period", bad_int, 0);
            check("sdo_stable_at_sample", bad_stable, 0);
            check("cs_during_xfer", bad_cs, 0);
            check("slave_capture", cap, txw & mask);
            if (stall_len > 0) check("freeze", bad_frz, 0);
            extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (done_m !== 1'b0 || busy_m !== 1'b0) extra++;
            end
            check("single_done_no_restart", extra, 0);
            check("rx_held", rx_m, exp_rx);
            check("sclk_idle_after", sclk_m, p_cpol);
        end
    endtask

    initial begin
        bit r16, rpol, rpha, rlsb, rloop;
        int rdiv, rsel;
        logic [15:0] rtx, rsw;

        rst = 1'b1; enable = 1'b1; cpol = 1'b1; cpha = 1'b0; lsb = 1'b0; start = 1'b0;
        sel16 = 1'b0; loop = 1'b1; slave_sdi = 1'b0; clk_div = '0; cs_select = '0; tx = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy_m, 1'b0);
        check("reset_done", done_m, 1'b0);
        check("reset_rx", rx_m, 16'h0);
        check("reset_sdo", sdo_m, 1'b0);
        check("reset_cs", cs_m, 4'hF);
        check("reset_sclk", sclk_m, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("sclk_follows_cpol", sclk_m, 1'b1);

        // Directed cases from the plan
        run_xfer(0, 0, 0, 0, 0, 0, 16'h00A5, 1, 16'h0000, -1, 0, -1, -1);
        run_xfer(0, 1, 1, 1, 3, 2, 16'h003C, 0, 16'h0081, -1, 0, -1, -1);
        run_xfer(1, 0, 1, 0, 1, 1, 16'hBEEF, 1, 16'h0000, -1, 0, -1, -1);
        run_xfer(1, 1, 0, 1, 2, 3, 16'hBEEF, 1, 16'h0000, -1, 0, -1, -1);
        run_xfer(0, 0, 0, 0, 1, 5, 16'h0093, 0, 16'h006E, -1, 0, 6, -1);
        run_xfer(0, 0, 0, 0, 0, 1, 16'h005A, 0, 16'h00C3, 8, 10, -1, -1);
        run_xfer(0, 0, 1, 0, 1, 0, 16'h00F0, 1, 16'h0000, -1, 0, -1, 12);
        run_xfer(0, 0, 1, 0, 1, 0, 16'h0F0F, 0, 16'h0071, -1, 0, -1, -1);

        for (int i = 0; i < 10; i++) begin
            r16   = 1'($urandom_range(0, 1));
            rpol  = 1'($urandom_range(0, 1));
            rpha  = 1'($urandom_range(0, 1));
            rlsb  = 1'($urandom_range(0, 1));
            rloop = 1'($urandom_range(0, 1));
            rdiv  = int'($urandom_range(0, 3));
            rsel  = int'($urandom_range(0, 4));
            rtx   = 16'($urandom);
            rsw   = 16'($urandom);
            run_xfer(r16, rpol, rpha, rlsb, rdiv, rsel, rtx, rloop, rsw, -1, 0, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
